// File: rtl/aes_pkg.sv
// Shared definitions for the serial AES-128 host: block width, host FSM states
// and the FIPS-197 appendix B reference vector.
package aes_pkg;

   localparam int unsigned AES_BLOCK_W = 128;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT,
      ST_RECV,
      ST_HOLD
   } host_state_t;

   localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

endpackage

// File: rtl/aes_serial_host_serdes_shift.sv
// Right-shifting register with parallel load: serial data leaves at bit 0 and
// enters at the MSB, so a full frame lands LSB-first in bit order.
module serdes_shift #(
   parameter int unsigned W = 128
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         shift,
   input  logic         shift_in,
   output logic [W-1:0] data,
   output logic         shift_out
);

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         data <= '0;
      end else if (load) begin
         data <= load_data;
      end else if (shift) begin
         data <= {shift_in, data[W-1:1]};
      end
   end

   assign shift_out = data[0];

endmodule

// File: rtl/aes_serial_host.sv
// Host-side peer of the bit-serial AES-128 core: serializes plaintext/key onto
// the core pins and deserializes the returned ciphertext frame.
module aes_serial_host
   import aes_pkg::*;
#(
   parameter int unsigned BLOCK_W     = AES_BLOCK_W,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [BLOCK_W-1:0] pt_in,
   input  logic [BLOCK_W-1:0] key_in,
   input  logic               req_valid,
   output logic               req_ready,
   output logic               ser_din,
   output logic               ser_kin,
   output logic               ser_en,
   input  logic               ser_dout,
   input  logic               ser_out_val,
   output logic [BLOCK_W-1:0] ct_out,
   output logic               ct_valid,
   input  logic               ct_ready,
   output logic               err_timeout,
   output logic               err_frame
);

   localparam int unsigned CNT_W = $clog2(BLOCK_W) + 1;
   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BLOCK_W - 1);
   localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYC);

   host_state_t state, state_nxt;

   logic [CNT_W-1:0]   bit_cnt;
   logic [TMR_W-1:0]   wait_tmr;
   logic               accept, last_bit, timer_done;
   logic               pt_lsb, key_lsb;
   logic               ct_shift, ct_clear;
   logic [BLOCK_W-1:0] pt_par_unused, key_par_unused;
   logic               ct_lsb_unused;

   assign accept     = (state == ST_IDLE) && req_valid;
   assign last_bit   = (bit_cnt == LAST_BIT);
   assign timer_done = (wait_tmr == TMR_MAX);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (req_valid) state_nxt = ST_SEND;
         ST_SEND: if (last_bit) state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (ser_out_val)     state_nxt = ST_RECV;
            else if (timer_done) state_nxt = ST_IDLE;
         end
         ST_RECV: begin
            if (!ser_out_val)  state_nxt = ST_IDLE;
            else if (last_bit) state_nxt = ST_HOLD;
         end
         ST_HOLD: if (ct_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready   = (state == ST_IDLE);
      ser_en      = (state == ST_SEND) || (state == ST_WAIT) || (state == ST_RECV);
      ser_din     = (state == ST_SEND) && pt_lsb;
      ser_kin     = (state == ST_SEND) && key_lsb;
      ct_valid    = (state == ST_HOLD);
      err_timeout = (state == ST_WAIT) && !ser_out_val && timer_done;
      err_frame   = (state == ST_RECV) && !ser_out_val;
      ct_shift    = ((state == ST_WAIT) || (state == ST_RECV)) && ser_out_val;
      ct_clear    = err_frame;
   end

   // Bit 0 of the received frame is captured in WAIT, so RECV starts counting at 1.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bit_cnt  <= '0;
         wait_tmr <= '0;
      end else begin
         unique case (state)
            ST_SEND: bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            ST_WAIT: bit_cnt <= ser_out_val ? CNT_W'(1) : '0;
            ST_RECV: bit_cnt <= (ser_out_val && !last_bit) ? bit_cnt + 1'b1 : '0;
            default: bit_cnt <= '0;
         endcase
         if (state != ST_WAIT) begin
            wait_tmr <= '0;
         end else if (!timer_done) begin
            wait_tmr <= wait_tmr + 1'b1;
         end
      end
   end

   serdes_shift #(.W(BLOCK_W)) u_pt_sh (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (1'b0),
      .load      (accept),
      .load_data (pt_in),
      .shift     (state == ST_SEND),
      .shift_in  (1'b0),
      .data      (pt_par_unused),
      .shift_out (pt_lsb)
   );

   serdes_shift #(.W(BLOCK_W)) u_key_sh (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (1'b0),
      .load      (accept),
      .load_data (key_in),
      .shift     (state == ST_SEND),
      .shift_in  (1'b0),
      .data      (key_par_unused),
      .shift_out (key_lsb)
   );

   serdes_shift #(.W(BLOCK_W)) u_ct_sh (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (ct_clear),
      .load      (1'b0),
      .load_data ('0),
      .shift     (ct_shift),
      .shift_in  (ser_dout),
      .data      (ct_out),
      .shift_out (ct_lsb_unused)
   );

endmodule
